// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer for the IFU: boots the PC, issues cache requests, latches IR and redirects the PC.
// Optional perf counters are compiled in when FETCH_PERF_CNT_EN is defined.
module ifu_fetch_ctrl #(
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 7,
  parameter int PERF_WIDTH   = 32
) (
  input  logic                  fetch_ctrl_clock_in,
  input  logic                  fetch_ctrl_reset_in,
  input  logic                  ins_mem_ready_in,
  input  logic                  ins_mem_hit_in,
  input  logic                  stall_in,
  input  logic                  branch_taken_in,
  input  logic                  jump_in,
  output logic                  pc_set_ctrl_out,
  output logic [1:0]            pc_src_mux_ctrl_out,
  output logic                  ins_mem_valid_ctrl_out,
  output logic                  ir_set_ctrl_out,
  output logic                  ir_valid_out,
  output logic                  fetch_err_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] perf_fetch_cnt_out,
  output logic [PERF_WIDTH-1:0] perf_miss_cnt_out
`endif
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_LATCH,
    ST_ADVANCE,
    ST_ERROR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(MISS_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] WAIT_MAX  = {CNT_WIDTH{1'b1}};

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] wait_cnt_reg;
  logic                 pend_valid_reg;
  logic                 pend_jump_reg;
  logic                 latch_ok_reg;

  logic       word_hit;
  logic       capture_en;
  logic       advance_go;
  logic [1:0] redirect_src;

  assign word_hit   = ins_mem_ready_in & ins_mem_hit_in;
  assign capture_en = (state_reg != ST_BOOT) && (state_reg != ST_ERROR);
  assign advance_go = (state_reg == ST_ADVANCE) && !stall_in;

  // A pulse arriving in the advancing cycle takes priority over the older pending redirect.
  always_comb begin
    redirect_src = 2'b00;
    if (jump_in)
      redirect_src = 2'b10;
    else if (branch_taken_in)
      redirect_src = 2'b01;
    else if (pend_valid_reg)
      redirect_src = pend_jump_reg ? 2'b10 : 2'b01;
  end

  always_ff @(posedge fetch_ctrl_clock_in or negedge fetch_ctrl_reset_in) begin
    if (!fetch_ctrl_reset_in) begin
      state_reg      <= ST_BOOT;
      wait_cnt_reg   <= '0;
      pend_valid_reg <= 1'b0;
      pend_jump_reg  <= 1'b0;
      latch_ok_reg   <= 1'b0;
    end else begin
      if (capture_en) begin
        if (jump_in) begin
          pend_valid_reg <= 1'b1;
          pend_jump_reg  <= 1'b1;
        end else if (branch_taken_in) begin
          pend_valid_reg <= 1'b1;
          pend_jump_reg  <= 1'b0;
        end
      end
      case (state_reg)
        ST_BOOT: state_reg <= ST_REQ;
        ST_REQ: begin
          if (word_hit) begin
            state_reg <= ST_LATCH;
          end else begin
            state_reg    <= ST_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg != WAIT_MAX)
            wait_cnt_reg <= wait_cnt_reg + CNT_WIDTH'(1);
          if (word_hit)
            state_reg <= ST_LATCH;
          else if (wait_cnt_reg == WAIT_LAST)
            state_reg <= ST_ERROR;
        end
        ST_LATCH: begin
          latch_ok_reg <= !pend_valid_reg;
          state_reg    <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          // Clearing here overrides any same-cycle capture: that pulse was already applied.
          if (!stall_in) begin
            state_reg      <= ST_REQ;
            pend_valid_reg <= 1'b0;
            pend_jump_reg  <= 1'b0;
          end
        end
        ST_ERROR: state_reg <= ST_ERROR;
        default:  state_reg <= ST_BOOT;
      endcase
    end
  end

  // BOOT is the reset state, so its outputs are masked while reset is held.
  always_comb begin
    pc_set_ctrl_out        = 1'b0;
    pc_src_mux_ctrl_out    = 2'b00;
    ins_mem_valid_ctrl_out = 1'b0;
    ir_set_ctrl_out        = 1'b0;
    ir_valid_out           = 1'b0;
    fetch_err_out          = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        pc_set_ctrl_out     = fetch_ctrl_reset_in;
        pc_src_mux_ctrl_out = fetch_ctrl_reset_in ? 2'b11 : 2'b00;
      end
      ST_REQ, ST_WAIT: ins_mem_valid_ctrl_out = 1'b1;
      ST_LATCH:        ir_set_ctrl_out = !pend_valid_reg;
      ST_ADVANCE: begin
        ir_valid_out        = latch_ok_reg;
        pc_set_ctrl_out     = advance_go;
        pc_src_mux_ctrl_out = advance_go ? redirect_src : 2'b00;
      end
      ST_ERROR: fetch_err_out = 1'b1;
      default: ;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_WIDTH-1:0] perf_fetch_cnt_reg;
  logic [PERF_WIDTH-1:0] perf_miss_cnt_reg;

  always_ff @(posedge fetch_ctrl_clock_in or negedge fetch_ctrl_reset_in) begin
    if (!fetch_ctrl_reset_in) begin
      perf_fetch_cnt_reg <= '0;
      perf_miss_cnt_reg  <= '0;
    end else begin
      if (ir_set_ctrl_out)
        perf_fetch_cnt_reg <= perf_fetch_cnt_reg + PERF_WIDTH'(1);
      if (state_reg == ST_WAIT)
        perf_miss_cnt_reg <= perf_miss_cnt_reg + PERF_WIDTH'(1);
    end
  end

  assign perf_fetch_cnt_out = perf_fetch_cnt_reg;
  assign perf_miss_cnt_out  = perf_miss_cnt_reg;
`else
  // Without the counters the width parameter has nothing to size.
  if (PERF_WIDTH < 1) begin : g_no_perf
  end
`endif

endmodule
